clock_setup_ctrl: RTL and testbench

//  Mode/position sequencer for the H:M:S clock datapath. Runs one clock with enables only, no derived clocks.
//  - CLOCK mode: turns the 1 Hz tick into sec/min/hour increment enables with carry.
//  - SET mode: steps the selected field from the increment button, freezes time and blinks the selected digit pair.
//  - Sits between the debounced buttons and the hms counters / led_disp blanking.

---
 rtl/clock_setup_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_clock_setup_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_setup_ctrl
//  Purpose  : Mode/position sequencer for the H:M:S clock datapath. In CLOCK
//             mode it turns the 1 Hz tick into sec/min/hour enables with
//             carry. In SET mode it steps the selected field from the
//             increment button, freezes time and blinks the selected digits.
//             Optional feature macro: CLOCK_SETUP_CTRL_AUTO_REPEAT_EN
//             (auto-repeat of a held increment button; adds HOLD_CYCLES and
//             REPEAT_CYCLES parameters and a 32-bit repeat counter).
//  Revision : 1.0  initial release
// ============================================================================
module clock_setup_ctrl #(
    parameter int TIMEOUT_S     = 30
`ifdef CLOCK_SETUP_CTRL_AUTO_REPEAT_EN
    ,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_1hz,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    input  logic       i_sec_max,
    input  logic       i_min_max,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_hou_inc,
    output logic [5:0] o_blank
);

    typedef enum logic [0:0] {
        ST_CLOCK = 1'b0,
        ST_SET   = 1'b1
    } state_t;

    localparam logic [7:0] c_timeout_lim = 8'(TIMEOUT_S);
    localparam logic [1:0] c_pos_sec     = 2'd0;
    localparam logic [1:0] c_pos_min     = 2'd1;
    localparam logic [1:0] c_pos_hou     = 2'd2;

    state_t     r_state,       w_state_nx;
    logic [1:0] r_position,    w_position_nx;
    logic [7:0] r_timeout_cnt, w_timeout_cnt_nx;
    logic       r_phase,       w_phase_nx;
    logic       r_sec_inc,     w_sec_inc_nx;
    logic       r_min_inc,     w_min_inc_nx;
    logic       r_hou_inc,     w_hou_inc_nx;
    logic [5:0] r_blank,       w_blank_nx;
    logic       r_prev_mode, r_prev_pos, r_prev_inc;
    logic       w_press_mode, w_press_pos, w_press_inc;
    logic       w_any_press;
    logic       w_repeat;

    // Rising-edge detection on the debounced button levels.
    assign w_press_mode = i_sw_mode & ~r_prev_mode;
    assign w_press_pos  = i_sw_pos  & ~r_prev_pos;
    assign w_press_inc  = i_sw_inc  & ~r_prev_inc;

`ifdef CLOCK_SETUP_CTRL_AUTO_REPEAT_EN
    localparam logic [31:0] c_hold_lim   = 32'(HOLD_CYCLES);
    localparam logic [31:0] c_repeat_lim = 32'(REPEAT_CYCLES);

    // r_rep_cnt == 0 means idle; otherwise it counts cycles held since the
    // press (or since the last repeat once r_rep_armed is set).
    logic [31:0] r_rep_cnt,   w_rep_cnt_nx;
    logic        r_rep_armed, w_rep_armed_nx;

    // Auto-repeat timing for a held increment button in SET mode.
    always_comb begin
        w_repeat       = 1'b0;
        w_rep_cnt_nx   = r_rep_cnt;
        w_rep_armed_nx = r_rep_armed;
        if (r_state != ST_SET || !i_sw_inc || w_press_mode || w_press_pos) begin
            w_rep_cnt_nx   = 32'd0;
            w_rep_armed_nx = 1'b0;
        end else if (w_press_inc) begin
            w_rep_cnt_nx   = 32'd1;
            w_rep_armed_nx = 1'b0;
        end else if (r_rep_cnt != 32'd0) begin
            if ((!r_rep_armed && r_rep_cnt == c_hold_lim) ||
                ( r_rep_armed && r_rep_cnt == c_repeat_lim)) begin
                w_repeat       = 1'b1;
                w_rep_cnt_nx   = 32'd1;
                w_rep_armed_nx = 1'b1;
            end else begin
                w_rep_cnt_nx = r_rep_cnt + 32'd1;
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= 32'd0;
            r_rep_armed <= 1'b0;
        end else begin
            r_rep_cnt   <= w_rep_cnt_nx;
            r_rep_armed <= w_rep_armed_nx;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // A repeat pulse behaves like a fresh press for timeout and blink.
    assign w_any_press = w_press_mode | w_press_pos | w_press_inc | w_repeat;

    // Next-state, increment enables and blanking; priority mode > pos > inc.
    always_comb begin
        w_state_nx       = r_state;
        w_position_nx    = r_position;
        w_timeout_cnt_nx = r_timeout_cnt;
        w_phase_nx       = r_phase;
        w_sec_inc_nx     = 1'b0;
        w_min_inc_nx     = 1'b0;
        w_hou_inc_nx     = 1'b0;
        w_blank_nx       = 6'b000000;
        case (r_state)
            ST_CLOCK: begin
                w_sec_inc_nx = i_tick_1hz;
                w_min_inc_nx = i_tick_1hz & i_sec_max;
                w_hou_inc_nx = i_tick_1hz & i_sec_max & i_min_max;
                if (w_press_mode) begin
                    w_state_nx       = ST_SET;
                    w_position_nx    = c_pos_sec;
                    w_timeout_cnt_nx = 8'd0;
                    w_phase_nx       = 1'b0;
                end
            end
            ST_SET: begin
                if (w_press_mode) begin
                    w_state_nx    = ST_CLOCK;
                    w_position_nx = c_pos_sec;
                end else if (w_press_pos) begin
                    w_position_nx = (r_position == c_pos_hou) ? c_pos_sec
                                                              : r_position + 2'd1;
                end else if (w_press_inc || w_repeat) begin
                    case (r_position)
                        c_pos_sec: w_sec_inc_nx = 1'b1;
                        c_pos_min: w_min_inc_nx = 1'b1;
                        c_pos_hou: w_hou_inc_nx = 1'b1;
                        default:   w_sec_inc_nx = 1'b0;
                    endcase
                end
                // A press in the timeout tick cycle wins over the timeout.
                if (w_any_press) begin
                    w_timeout_cnt_nx = 8'd0;
                    w_phase_nx       = 1'b0;
                end else if (i_tick_1hz) begin
                    if (r_timeout_cnt + 8'd1 == c_timeout_lim) begin
                        w_state_nx       = ST_CLOCK;
                        w_position_nx    = c_pos_sec;
                        w_timeout_cnt_nx = 8'd0;
                        w_phase_nx       = 1'b0;
                    end else begin
                        w_timeout_cnt_nx = r_timeout_cnt + 8'd1;
                        w_phase_nx       = ~r_phase;
                    end
                end
            end
            default: w_state_nx = ST_CLOCK;
        endcase
        if (w_state_nx == ST_SET && w_phase_nx) begin
            case (w_position_nx)
                c_pos_sec: w_blank_nx = 6'b000011;
                c_pos_min: w_blank_nx = 6'b001100;
                c_pos_hou: w_blank_nx = 6'b110000;
                default:   w_blank_nx = 6'b000000;
            endcase
        end
    end

    // State and output registers; button history resets high so a button
    // held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_CLOCK;
            r_position    <= c_pos_sec;
            r_timeout_cnt <= 8'd0;
            r_phase       <= 1'b0;
            r_sec_inc     <= 1'b0;
            r_min_inc     <= 1'b0;
            r_hou_inc     <= 1'b0;
            r_blank       <= 6'b000000;
            r_prev_mode   <= 1'b1;
            r_prev_pos    <= 1'b1;
            r_prev_inc    <= 1'b1;
        end else begin
            r_state       <= w_state_nx;
            r_position    <= w_position_nx;
            r_timeout_cnt <= w_timeout_cnt_nx;
            r_phase       <= w_phase_nx;
            r_sec_inc     <= w_sec_inc_nx;
            r_min_inc     <= w_min_inc_nx;
            r_hou_inc     <= w_hou_inc_nx;
            r_blank       <= w_blank_nx;
            r_prev_mode   <= i_sw_mode;
            r_prev_pos    <= i_sw_pos;
            r_prev_inc    <= i_sw_inc;
        end
    end

    assign o_mode     = (r_state == ST_SET);
    assign o_position = r_position;
    assign o_sec_inc  = r_sec_inc;
    assign o_min_inc  = r_min_inc;
    assign o_hou_inc  = r_hou_inc;
    assign o_blank    = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_clock_setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_setup_ctrl
//  Purpose  : Directed self-checking bench for clock_setup_ctrl (TIMEOUT_S=3;
//             HOLD_CYCLES=10, REPEAT_CYCLES=4 when
//             CLOCK_SETUP_CTRL_AUTO_REPEAT_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_setup_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_tick_1hz, i_sw_mode, i_sw_pos, i_sw_inc, i_sec_max, i_min_max;
    logic       o_mode;
    logic [1:0] o_position;
    logic       o_sec_inc, o_min_inc, o_hou_inc;
    logic [5:0] o_blank;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_setup_ctrl #(
        .TIMEOUT_S(3)
`ifdef CLOCK_SETUP_CTRL_AUTO_REPEAT_EN
        ,
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick_1hz (i_tick_1hz),
        .i_sw_mode  (i_sw_mode),
        .i_sw_pos   (i_sw_pos),
        .i_sw_inc   (i_sw_inc),
        .i_sec_max  (i_sec_max),
        .i_min_max  (i_min_max),
        .o_mode     (o_mode),
        .o_position (o_position),
        .o_sec_inc  (o_sec_inc),
        .o_min_inc  (o_min_inc),
        .o_hou_inc  (o_hou_inc),
        .o_blank    (o_blank)
    );

    // Advance one clock; inputs set before the call are sampled at this edge
    // and the registered response is visible on return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed view {mode, position, sec, min, hou, blank}.
    function automatic logic [31:0] pk(input logic m, input logic [1:0] p, input logic s,
                                       input logic mi, input logic h, input logic [5:0] b);
        return {20'd0, m, p, s, mi, h, b};
    endfunction

    function automatic logic [31:0] obs_all();
        return pk(o_mode, o_position, o_sec_inc, o_min_inc, o_hou_inc, o_blank);
    endfunction

    initial begin
        rst = 1'b1; i_tick_1hz = 1'b0; i_sw_mode = 1'b1; i_sw_pos = 1'b0;
        i_sw_inc = 1'b0; i_sec_max = 1'b0; i_min_max = 1'b0;
        step(); step(); step();
        check("reset_state", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));

        // Mode button held through reset release must not toggle mode.
        rst = 1'b0;
        step(); step();
        check("held_mode_thru_rst", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        i_sw_mode = 1'b0; step();

        // CLOCK: three plain ticks, one sec pulse each, one cycle long.
        for (int k = 0; k < 3; k++) begin
            i_tick_1hz = 1'b1; step();
            i_tick_1hz = 1'b0;
            check("clock_tick_sec", obs_all(), pk(0, 0, 1, 0, 0, 6'b0));
            step();
            check("clock_tick_gap", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        end

        // Carry chain.
        i_sec_max = 1'b1; i_min_max = 1'b1; i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("carry_full", obs_all(), pk(0, 0, 1, 1, 1, 6'b0));
        i_min_max = 1'b0; step();
        check("carry_idle", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("carry_sec_only", obs_all(), pk(0, 0, 1, 1, 0, 6'b0));
        i_sec_max = 1'b0;

        // CLOCK ignores pos/inc.
        i_sw_pos = 1'b1; i_sw_inc = 1'b1; step();
        check("clock_ignores_pos_inc", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        i_sw_pos = 1'b0; i_sw_inc = 1'b0; step();

        // SET entry, position to HOU, single inc pulse.
        i_sw_mode = 1'b1; step();
        check("enter_set", obs_all(), pk(1, 0, 0, 0, 0, 6'b0));
        i_sw_mode = 1'b0; step();
        i_sw_pos = 1'b1; step();
        check("pos_to_min", obs_all(), pk(1, 1, 0, 0, 0, 6'b0));
        i_sw_pos = 1'b0; step();
        i_sw_pos = 1'b1; step();
        check("pos_to_hou", obs_all(), pk(1, 2, 0, 0, 0, 6'b0));
        i_sw_pos = 1'b0; step();
        i_sw_inc = 1'b1; step();
        check("set_inc_hou", obs_all(), pk(1, 2, 0, 0, 1, 6'b0));
        step();
        check("set_inc_single", obs_all(), pk(1, 2, 0, 0, 0, 6'b0));
        i_sw_inc = 1'b0; step();
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("set_tick_no_inc_blink_hou", obs_all(), pk(1, 2, 0, 0, 0, 6'b110000));
        step();

        // Pos wraps HOU->SEC and clears blink; then move to MIN.
        i_sw_pos = 1'b1; step();
        check("pos_wrap_sec", obs_all(), pk(1, 0, 0, 0, 0, 6'b0));
        i_sw_pos = 1'b0; step();
        i_sw_pos = 1'b1; step();
        i_sw_pos = 1'b0; step();
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("blink_min_on", obs_all(), pk(1, 1, 0, 0, 0, 6'b001100));
        step();
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("blink_min_off", obs_all(), pk(1, 1, 0, 0, 0, 6'b0));
        step();
        i_sw_inc = 1'b1; step();
        check("inc_min_clears_cnt", obs_all(), pk(1, 1, 0, 1, 0, 6'b0));
        i_sw_inc = 1'b0; step();
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("blink_min_on2", obs_all(), pk(1, 1, 0, 0, 0, 6'b001100));
        step();
        i_sw_inc = 1'b1; step();
        check("inc_clears_blank", obs_all(), pk(1, 1, 0, 1, 0, 6'b0));
        i_sw_inc = 1'b0; step();

        // Timeout after three quiet ticks.
        for (int k = 0; k < 2; k++) begin
            i_tick_1hz = 1'b1; step();
            i_tick_1hz = 1'b0;
            check("timeout_not_yet", {31'd0, o_mode}, 32'd1);
            step();
        end
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("timeout_fire", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        step();

        // Press on the third tick cancels the timeout.
        i_sw_mode = 1'b1; step();
        i_sw_mode = 1'b0; step();
        for (int k = 0; k < 2; k++) begin
            i_tick_1hz = 1'b1; step();
            i_tick_1hz = 1'b0; step();
        end
        i_tick_1hz = 1'b1; i_sw_pos = 1'b1; step();
        i_tick_1hz = 1'b0; i_sw_pos = 1'b0;
        check("press_cancels_timeout", obs_all(), pk(1, 1, 0, 0, 0, 6'b0));
        step();
        for (int k = 0; k < 2; k++) begin
            i_tick_1hz = 1'b1; step();
            i_tick_1hz = 1'b0; step();
        end
        check("timer_restarted", {31'd0, o_mode}, 32'd1);
        i_tick_1hz = 1'b1; step();
        i_tick_1hz = 1'b0;
        check("timeout_after_restart", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        step();

        // Simultaneous pos+inc: pos wins, inc discarded and not queued.
        i_sw_mode = 1'b1; step();
        i_sw_mode = 1'b0; step();
        i_sw_pos = 1'b1; i_sw_inc = 1'b1; step();
        check("pos_beats_inc", obs_all(), pk(1, 1, 0, 0, 0, 6'b0));
        i_sw_pos = 1'b0; i_sw_inc = 1'b0; step();
        check("inc_not_queued", obs_all(), pk(1, 1, 0, 0, 0, 6'b0));

        // Simultaneous mode+pos: mode wins.
        i_sw_mode = 1'b1; i_sw_pos = 1'b1; step();
        check("mode_beats_pos", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        i_sw_mode = 1'b0; i_sw_pos = 1'b0; step();

        // SET inc at SEC gives no carry even with max flags high.
        i_sw_mode = 1'b1; step();
        i_sw_mode = 1'b0; step();
        i_sec_max = 1'b1; i_min_max = 1'b1; i_sw_inc = 1'b1; step();
        check("set_inc_no_carry", obs_all(), pk(1, 0, 1, 0, 0, 6'b0));
        i_sec_max = 1'b0; i_min_max = 1'b0; i_sw_inc = 1'b0; step();

        // Reset mid-SET returns to CLOCK with no pulse.
        i_sw_inc = 1'b1; rst = 1'b1; step();
        check("reset_mid_set", obs_all(), pk(0, 0, 0, 0, 0, 6'b0));
        rst = 1'b0; i_sw_inc = 1'b0; step();

        // Held inc in SET: one pulse, plus repeats when the feature is built.
        i_sw_mode = 1'b1; step();
        i_sw_mode = 1'b0; step();
        for (int k = 0; k < 24; k++) begin
            logic exp_pulse;
            i_sw_inc = (k < 20) ? 1'b1 : 1'b0;
            step();
`ifdef CLOCK_SETUP_CTRL_AUTO_REPEAT_EN
            exp_pulse = (k == 0 || k == 10 || k == 14 || k == 18);
`else
            exp_pulse = (k == 0);
`endif
            check($sformatf("held_inc_k%0d", k), obs_all(), pk(1, 0, exp_pulse, 0, 0, 6'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
